// File: rtl/alu_control_md.sv
// ALU control decode plus a HI/LO unit doing iterative multiply/divide.
// Each op runs W shift-add or restoring steps, then one cycle applies the signs.
module alu_control_md #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   Aluop,
  input  logic [5:0]   funct,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [3:0]   controlline,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [W-1:0]    md_q, md_d;
  logic [W-1:0]    acc_hi_q, acc_hi_d;
  logic [W-1:0]    acc_lo_q, acc_lo_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            div0_q, div0_d;

  logic            signed_op;
  logic [W-1:0]    mag_a, mag_b, addend;
  logic [W:0]      add_sum, shifted, diff;
  logic [2*W-1:0]  prod, prod_neg;

  // Combinational ALU operation select
  always_comb begin
    controlline = 4'b0010;
    case (Aluop)
      2'b00: controlline = 4'b0010;
      2'b01: controlline = 4'b0110;
      2'b11: controlline = 4'b0111;
      default: begin
        case (funct)
          6'b100000, 6'b100001: controlline = 4'b0010;
          6'b100010, 6'b100011: controlline = 4'b0110;
          6'b100100: controlline = 4'b0000;
          6'b100101: controlline = 4'b0001;
          6'b100110: controlline = 4'b0011;
          6'b100111: controlline = 4'b1100;
          6'b101010: controlline = 4'b0111;
          6'b101011: controlline = 4'b1111;
          default:   controlline = 4'b0010;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    dvd_d    = dvd_q;
    md_d     = md_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;

    signed_op = ~funct[0];
    mag_a     = (signed_op && a[W-1]) ? ({W{1'b0}} - a) : a;
    mag_b     = (signed_op && b[W-1]) ? ({W{1'b0}} - b) : b;
    addend    = acc_lo_q[0] ? md_q : {W{1'b0}};
    add_sum   = {1'b0, acc_hi_q} + {1'b0, addend};
    // Restoring step: bit W of diff is the borrow
    shifted   = {acc_hi_q, acc_lo_q[W-1]};
    diff      = shifted - {1'b0, md_q};
    prod      = {acc_hi_q, acc_lo_q};
    prod_neg  = {(2*W){1'b0}} - prod;

    case (state_q)
      IDLE: begin
        if (start && Aluop == 2'b10) begin
          case (funct)
            F_MTHI: hi_d = a;
            F_MTLO: lo_d = a;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d  = ITER;
              busy_d   = 1'b1;
              cnt_d    = '0;
              is_div_d = funct[1];
              neg_d    = signed_op & (a[W-1] ^ b[W-1]);
              rneg_d   = signed_op & a[W-1];
              dz_d     = funct[1] & (b == {W{1'b0}});
              dvd_d    = a;
              md_d     = mag_b;
              acc_hi_d = '0;
              acc_lo_d = mag_a;
            end
            default: ;
          endcase
        end
      end
      ITER: begin
        if (is_div_q) begin
          if (!diff[W]) begin
            acc_hi_d = diff[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
          end else begin
            acc_hi_d = shifted[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = add_sum[W:1];
          acc_lo_d = {add_sum[0], acc_lo_q[W-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (dz_q) begin
            hi_d   = dvd_q;
            lo_d   = {W{1'b1}};
            div0_d = 1'b1;
          end else begin
            lo_d = neg_q  ? ({W{1'b0}} - acc_lo_q) : acc_lo_q;
            hi_d = rneg_q ? ({W{1'b0}} - acc_hi_q) : acc_hi_q;
          end
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dvd_q    <= '0;
      md_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      dvd_q    <= dvd_d;
      md_q     <= md_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: directed spot checks plus random traffic, all
// checked every cycle against a 64-bit arithmetic reference model.
module tb_alu_control_md;
  localparam int unsigned W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    aluop;
  logic [5:0]    funct;
  logic          start;
  logic [W-1:0]  a, b;
  logic [3:0]    controlline;
  logic          busy, done, div0;
  logic [W-1:0]  hi, lo;

  int n_vec = 0;
  int n_mis = 0;

  alu_control_md #(.W(W)) dut (
    .clk(clk), .reset(reset), .Aluop(aluop), .funct(funct), .start(start),
    .a(a), .b(b), .controlline(controlline), .busy(busy), .done(done),
    .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0111;
    case (f)
      6'b100000, 6'b100001: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  task automatic ref_result(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint sp, q, r;
    longint unsigned up;
    dz = 1'b0;
    rh = '0;
    rl = '0;
    if (f == F_MULT) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      {rh, rl} = sp;
    end else if (f == F_MULTU) begin
      up = {32'd0, x} * {32'd0, y};
      {rh, rl} = up;
    end else if (y == 32'd0) begin
      rh = x;
      rl = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (f == F_DIV) begin
      q  = longint'($signed(x)) / longint'($signed(y));
      r  = longint'($signed(x)) % longint'($signed(y));
      rl = q[31:0];
      rh = r[31:0];
    end else begin
      rl = x / y;
      rh = x % y;
    end
  endtask

  // Reference: an op occupies W+1 cycles, then its result lands with done
  int           m_cnt;
  logic [31:0]  m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_div0, p_div0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_div0 = 1'b0;
    end else begin
      m_done = 1'b0;
      m_div0 = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_div0 = p_div0;
        end
      end else if (start && aluop == 2'b10) begin
        if (funct == F_MTHI) m_hi = a;
        else if (funct == F_MTLO) m_lo = a;
        else if (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU) begin
          ref_result(funct, a, b, p_hi, p_lo, p_div0);
          m_cnt = W + 1;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    aluop = op; funct = f; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 11))
      0: return F_MULT;
      1: return F_MULTU;
      2: return F_DIV;
      3: return F_DIVU;
      4: return F_MTHI;
      5: return F_MTLO;
      6: return 6'b100000;
      7: return 6'b100111;
      8: return 6'b101010;
      9: return 6'b100110;
      10: return 6'b100100;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b1; start = 1'b0; aluop = 2'b00; funct = '0; a = '0; b = '0;

    fork
      forever begin
        @(negedge clk);
        chk("busy", busy, m_cnt > 0);
        chk("done", done, m_done);
        chk("div0", div0, m_div0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("ctrl", controlline, ref_ctrl(aluop, funct));
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    aluop = 2'b10; funct = 6'b100010; #1 chk("ctrl_sub", controlline, 4'b0110);
    funct = 6'b101011; #1 chk("ctrl_sltu", controlline, 4'b1111);
    funct = 6'b111111; #1 chk("ctrl_other", controlline, 4'b0010);
    chk("ctrl_busy", busy, 0);
    @(posedge clk); #1;

    issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_done(nb);
    chk("multu_busy_len", nb, 33);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    issue(2'b10, F_MULT, 32'hFFFF_FFFD, 32'h5);
    wait_done(nb);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    @(posedge clk); #1;

    issue(2'b10, F_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_done(nb);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    issue(2'b10, F_DIVU, 32'h9, 32'h0);
    wait_done(nb);
    chk("div0_flag", div0, 1);
    chk("div0_hi", hi, 32'h9);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    issue(2'b10, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    @(posedge clk); #1;

    // Busy-time start is ignored; reset mid-op aborts at once
    issue(2'b10, F_MULT, 32'h7, 32'h9);
    repeat (4) @(posedge clk);
    #1;
    aluop = 2'b10; funct = F_DIV; a = 32'h55; b = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(2'b10, F_MULTU, 32'h3, 32'h4);
    wait_done(nb);
    chk("post_rst_lo", lo, 32'hC);
    chk("post_rst_hi", hi, 32'h0);
    @(posedge clk); #1;

    issue(2'b10, F_MTHI, 32'h1234_5678, 32'h0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    issue(2'b00, F_MTLO, 32'hDEAD_BEEF, 32'h0);
    chk("aluop00_lo", lo, 32'hC);
    chk("aluop00_hi", hi, 32'h1234_5678);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      aluop = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      funct = pick_funct();
      a = pick_val();
      b = pick_val();
      @(posedge clk); #1;
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
